// File: rtl/fmult_accum_seq_pkg.sv
// Shared constants and state encoding for the sequential FMULT accumulator.
// Contents:
//   state_t          - controller states (IDLE, MAC, DONE)
//   NTAPS_Z/NTAPS_P  - zero-predictor (6) and pole-predictor (2) tap counts
//   COEF_W/FLT_W     - coefficient width (16) and float operand width (11)
//   OUT_W            - SEZ/SE estimate width (15)
//   IDX_SEZ/IDX_LAST - tap indices at which SEZI is captured and the MAC ends
package fmult_accum_seq_pkg;

    localparam int unsigned NTAPS_Z = 6;
    localparam int unsigned NTAPS_P = 2;
    localparam int unsigned NTAPS   = NTAPS_Z + NTAPS_P;
    localparam int unsigned COEF_W  = 16;
    localparam int unsigned FLT_W   = 11;
    localparam int unsigned OUT_W   = 15;
    localparam int unsigned IDX_W   = 3;

    localparam logic [IDX_W-1:0] IDX_SEZ  = IDX_W'(NTAPS_Z - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fmult_accum_seq_if.sv
// Operand/result bundle for fmult_accum_seq.
// Signals:
//   start          - request a new prediction (master -> slave)
//   B1..B6, A1, A2 - 16-bit two's-complement predictor coefficients
//   DQ1..DQ6       - 11-bit float delayed quantized differences
//   SR1, SR2       - 11-bit float delayed reconstructed signal
//   SEZ, SE        - 15-bit partial / full signal estimates (slave -> master)
//   busy, done     - operation in progress / one-cycle completion pulse
interface fmult_accum_seq_if;
    import fmult_accum_seq_pkg::*;

    logic              start;
    logic [COEF_W-1:0] B1, B2, B3, B4, B5, B6;
    logic [FLT_W-1:0]  DQ1, DQ2, DQ3, DQ4, DQ5, DQ6;
    logic [COEF_W-1:0] A1, A2;
    logic [FLT_W-1:0]  SR1, SR2;
    logic [OUT_W-1:0]  SEZ;
    logic [OUT_W-1:0]  SE;
    logic              busy;
    logic              done;

    modport master (
        output start, B1, B2, B3, B4, B5, B6, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
               A1, A2, SR1, SR2,
        input  SEZ, SE, busy, done
    );

    modport slave (
        input  start, B1, B2, B3, B4, B5, B6, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
               A1, A2, SR1, SR2,
        output SEZ, SE, busy, done
    );

endinterface

// File: rtl/fmult_accum_seq_fmult.sv
// G.726 FMULT: combinational product of a 16-bit two's-complement
// coefficient and an 11-bit float operand {sign, exp[3:0], mant[5:0]}.
// Ports:
//   i_an - coefficient An (16)
//   i_sr - float operand SRn/DQn (11)
//   o_w  - signed product W (16)
module fmult
    import fmult_accum_seq_pkg::*;
(
    input  logic [COEF_W-1:0] i_an,
    input  logic [FLT_W-1:0]  i_sr,
    output logic [COEF_W-1:0] o_w
);

    logic [15:0] w_an_abs;
    logic [12:0] w_anmag;
    logic [3:0]  w_anexp;
    logic [18:0] w_mag_sh;
    logic [5:0]  w_anmant;
    logic [11:0] w_prod;
    logic [7:0]  w_wmant;
    logic [4:0]  w_wexp;
    logic [14:0] w_wm7;
    logic [14:0] w_wmag;
    logic        w_sgn;

    always_comb begin
        // Magnitude is kept to 13 bits, so An = -32768 folds to zero.
        w_an_abs = i_an[15] ? (16'd0 - i_an) : i_an;
        w_anmag  = 13'(w_an_abs >> 2);

        // Exponent is the number of significant bits (leading one position + 1).
        w_anexp = 4'd0;
        for (int unsigned k = 0; k < 13; k++) begin
            if (w_anmag[k]) begin
                w_anexp = 4'(k + 1);
            end
        end

        w_mag_sh = {w_anmag, 6'b0} >> w_anexp;
        w_anmant = (w_anmag == 13'd0) ? 6'd32 : w_mag_sh[5:0];

        w_prod  = 12'(i_sr[5:0]) * 12'(w_anmant);
        w_wmant = 8'(({1'b0, w_prod} + 13'd48) >> 4);
        w_wexp  = {1'b0, i_sr[9:6]} + {1'b0, w_anexp};

        // Left-shift case truncates to 15 bits, matching the & 0x7FFF mask.
        w_wm7 = {w_wmant, 7'b0};
        if (w_wexp <= 5'd26) begin
            w_wmag = w_wm7 >> (5'd26 - w_wexp);
        end else begin
            w_wmag = w_wm7 << (w_wexp - 5'd26);
        end

        w_sgn = i_sr[10] ^ i_an[15];
        o_w   = w_sgn ? (16'd0 - {1'b0, w_wmag}) : {1'b0, w_wmag};
    end

endmodule

// File: rtl/fmult_accum_seq.sv
// Sequential G.726 predictor: one shared FMULT stepped over 6 zero taps
// (Bk x DQk) and 2 pole taps (Ak x SRk), accumulated modulo 2^16.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active low
//   bus   - operand/result bundle (slave side): start, B1..B6, DQ1..DQ6,
//           A1, A2, SR1, SR2 in; SEZ, SE, busy, done out
module fmult_accum_seq
    import fmult_accum_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    fmult_accum_seq_if.slave  bus
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_acc;
    logic [OUT_W-1:0]  r_sezi;
    logic [OUT_W-1:0]  r_sez;
    logic [OUT_W-1:0]  r_se;
    logic              r_busy;
    logic              r_done;

    logic [COEF_W-1:0] r_coef [NTAPS];
    logic [FLT_W-1:0]  r_flt  [NTAPS];

    logic [COEF_W-1:0] w_an;
    logic [FLT_W-1:0]  w_sr;
    logic [15:0]       w_w;
    logic [15:0]       w_sum;

    // Operands are captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.start) begin
            r_coef[0] <= bus.B1;  r_flt[0] <= bus.DQ1;
            r_coef[1] <= bus.B2;  r_flt[1] <= bus.DQ2;
            r_coef[2] <= bus.B3;  r_flt[2] <= bus.DQ3;
            r_coef[3] <= bus.B4;  r_flt[3] <= bus.DQ4;
            r_coef[4] <= bus.B5;  r_flt[4] <= bus.DQ5;
            r_coef[5] <= bus.B6;  r_flt[5] <= bus.DQ6;
            r_coef[6] <= bus.A1;  r_flt[6] <= bus.SR1;
            r_coef[7] <= bus.A2;  r_flt[7] <= bus.SR2;
        end
    end

    assign w_an  = r_coef[r_idx];
    assign w_sr  = r_flt[r_idx];
    assign w_sum = r_acc + w_w;

    fmult u_fmult (
        .i_an (w_an),
        .i_sr (w_sr),
        .o_w  (w_w)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sezi  <= '0;
            r_sez   <= '0;
            r_se    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_MAC;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    // SEZI keeps only the bits that reach SEZ.
                    if (r_idx == IDX_SEZ) begin
                        r_sezi <= w_sum[15:1];
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_sez   <= r_sezi;
                    r_se    <= r_acc[15:1];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SEZ  = r_sez;
    assign bus.SE   = r_se;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Scoreboard bench for fmult_accum_seq: directed G.726 vectors, start-while-busy,
// reset abort, then randomized operations against an integer reference model.
module tb_fmult_accum_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fmult_accum_seq_if bus ();

    fmult_accum_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sez;
        int se;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_accept = 0;
    int   cyc      = 0;

    logic [15:0] b  [6];
    logic [10:0] dq [6];
    logic [15:0] a  [2];
    logic [10:0] sr [2];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // G.726 FMULT computed with plain integer arithmetic.
    function automatic int fmult_ref(input int an, input int srn);
        int anmag, anexp, anmant, wmant, wexp, wmag, sgn;
        anmag = (((an >= 32768) ? (65536 - an) : an) >> 2) % 8192;
        anexp = 0;
        while ((1 << anexp) <= anmag) anexp++;
        anmant = (anmag == 0) ? 32 : ((anmag << 6) >> anexp);
        wmant  = (((srn % 64) * anmant) + 48) >> 4;
        wexp   = ((srn / 64) % 16) + anexp;
        if (wexp <= 26) wmag = (wmant * 128) >> (26 - wexp);
        else            wmag = ((wmant * 128) << (wexp - 26)) % 32768;
        sgn = ((srn / 1024) % 2) ^ ((an >= 32768) ? 1 : 0);
        return sgn ? ((65536 - wmag) % 65536) : wmag;
    endfunction

    task automatic model(output int sez, output int se);
        int acc;
        acc = 0;
        for (int k = 0; k < 6; k++) acc = (acc + fmult_ref(int'(b[k]), int'(dq[k]))) % 65536;
        sez = acc / 2;
        for (int k = 0; k < 2; k++) acc = (acc + fmult_ref(int'(a[k]), int'(sr[k]))) % 65536;
        se = acc / 2;
    endtask

    task automatic drive_operands();
        bus.B1 = b[0]; bus.B2 = b[1]; bus.B3 = b[2];
        bus.B4 = b[3]; bus.B5 = b[4]; bus.B6 = b[5];
        bus.DQ1 = dq[0]; bus.DQ2 = dq[1]; bus.DQ3 = dq[2];
        bus.DQ4 = dq[3]; bus.DQ5 = dq[4]; bus.DQ6 = dq[5];
        bus.A1 = a[0]; bus.A2 = a[1];
        bus.SR1 = sr[0]; bus.SR2 = sr[1];
    endtask

    task automatic scramble_inputs();
        bus.B1 = 16'($urandom); bus.B2 = 16'($urandom); bus.B3 = 16'($urandom);
        bus.B4 = 16'($urandom); bus.B5 = 16'($urandom); bus.B6 = 16'($urandom);
        bus.DQ1 = 11'($urandom); bus.DQ2 = 11'($urandom); bus.DQ3 = 11'($urandom);
        bus.DQ4 = 11'($urandom); bus.DQ5 = 11'($urandom); bus.DQ6 = 11'($urandom);
        bus.A1 = 16'($urandom); bus.A2 = 16'($urandom);
        bus.SR1 = 11'($urandom); bus.SR2 = 11'($urandom);
    endtask

    task automatic clear_operands();
        for (int k = 0; k < 6; k++) begin b[k] = '0; dq[k] = '0; end
        for (int k = 0; k < 2; k++) begin a[k] = '0; sr[k] = '0; end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input int sez, input int se);
        exp_t e;
        int   t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("wait_idle_timeout", 32'(t), 32'd0);
        drive_operands();
        bus.start = 1'b1;
        e.sez = sez;
        e.se  = se;
        e.due = cyc + 10;
        sb.push_back(e);
        n_accept++;
        @(negedge clk);
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending operation", cyc);
            end else begin
                e = sb.pop_front();
                check("SEZ", 32'(bus.SEZ), 32'(e.sez));
                check("SE", 32'(bus.SE), 32'(e.se));
                check("done_latency_cycle", 32'(cyc), 32'(e.due));
                check("busy_low_with_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        int sez, se, mode;
        reset = 1'b0;
        bus.start = 1'b0;
        clear_operands();
        drive_operands();
        repeat (3) @(negedge clk);
        check("reset_SEZ", 32'(bus.SEZ), 32'd0);
        check("reset_SE", 32'(bus.SE), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // All-zero operands.
        clear_operands();
        issue(0, 0);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_drain();

        // B1 = +16384, DQ1 = 0x1E0 -> W = 134.
        clear_operands();
        b[0] = 16'd16384; dq[0] = 11'h1E0;
        issue(67, 67);
        wait_drain();

        // B1 = -16384 -> W = 0xFF7A.
        clear_operands();
        b[0] = 16'hC000; dq[0] = 11'h1E0;
        issue(15'h7FBD, 15'h7FBD);
        wait_drain();

        // Pole-only path, with start pulses during MAC and during DONE.
        clear_operands();
        a[0] = 16'd16384; sr[0] = 11'h1E0;
        issue(0, 67);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("single_done_after_ignored_starts", 32'(n_done), 32'd4);
        check("outputs_hold_SE", 32'(bus.SE), 32'd67);

        // Reset abort at MAC index 4, then an immediate new operation.
        clear_operands();
        b[0] = 16'd16384; dq[0] = 11'h1E0;
        issue(67, 67);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        n_accept--;
        @(negedge clk);
        check("abort_SEZ", 32'(bus.SEZ), 32'd0);
        check("abort_SE", 32'(bus.SE), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        clear_operands();
        b[0] = 16'hC000; dq[0] = 11'h1E0;
        issue(15'h7FBD, 15'h7FBD);
        wait_drain();

        // Randomized operations against the reference model.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 6; k++) begin
                mode = int'($urandom_range(3));
                case (mode)
                    0: b[k] = 16'($urandom);
                    1: b[k] = 16'($urandom_range(0, 255)) - 16'd128;
                    2: b[k] = ($urandom_range(1) == 0) ? 16'h8000 : 16'h7FFF;
                    default: b[k] = 16'($urandom) >>> $urandom_range(8);
                endcase
                dq[k] = 11'($urandom);
            end
            for (int k = 0; k < 2; k++) begin
                a[k]  = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
                sr[k] = 11'($urandom);
            end
            model(sez, se);
            issue(sez, se);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        check("done_count_equals_accepts", 32'(n_done), 32'(n_accept));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
